// File: rtl/bcd_sevenseg_if.sv
// Handshake and result bundle between a binary source and the BCD/seven-segment converter.
interface bcd_sevenseg_seq_if #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned DIGITS = 8
);
   logic                  start;
   logic [WIDTH-1:0]      binary;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   bcd;
   logic [7*DIGITS-1:0]   hex;
   logic                  overflow;

   modport master (
      output start, binary,
      input  busy, done, bcd, hex, overflow
   );

   modport slave (
      input  start, binary,
      output busy, done, bcd, hex, overflow
   );
endinterface

// File: rtl/bcd_sevenseg_seq.sv
// Multi-cycle binary-to-BCD converter (shift-add-3) with per-digit active-low
// seven-segment encoding, leading-zero blanking and overflow dashes.
module bcd_sevenseg_seq #(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned DIGITS   = 8,
   parameter int unsigned BLANK_LZ = 1
) (
   input logic              clock,
   input logic              resetn,
   bcd_sevenseg_seq_if.slave bus
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [6:0] SEG_BLANK = 7'b111_1111;
   localparam logic [6:0] SEG_DASH  = 7'b011_1111;

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t                state, state_n;
   logic                  accept;
   logic [WIDTH-1:0]      shreg;
   logic [4*DIGITS-1:0]   scratch, scratch_adj;
   logic                  ovf_flag;
   logic [CW-1:0]         cnt;
   logic [4*DIGITS-1:0]   bcd_q;
   logic [7*DIGITS-1:0]   hex_q, hex_next;
   logic                  ovf_q, done_q;
   logic                  lead_zero;
   logic [3:0]            digit;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b100_0000;
         4'd1:    return 7'b111_1001;
         4'd2:    return 7'b010_0100;
         4'd3:    return 7'b011_0000;
         4'd4:    return 7'b001_1001;
         4'd5:    return 7'b001_0010;
         4'd6:    return 7'b000_0010;
         4'd7:    return 7'b111_1000;
         4'd8:    return 7'b000_0000;
         4'd9:    return 7'b001_0000;
         default: return SEG_BLANK;
      endcase
   endfunction

   // State register
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state <= S_IDLE;
      else         state <= state_n;
   end

   // Next-state and accept decode; start is honoured whenever not busy
   always_comb begin
      state_n = state;
      accept  = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.start) begin
               accept  = 1'b1;
               state_n = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (cnt == '0) state_n = S_DONE;
         end
         S_DONE: begin
            if (bus.start) begin
               accept  = 1'b1;
               state_n = S_SHIFT;
            end else begin
               state_n = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Add-3 correction on every scratch digit that is 5 or more
   always_comb begin
      scratch_adj = scratch;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (scratch[4*i +: 4] >= 4'd5) scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
   end

   // Display encode of the finished scratch value, scanned from the top digit down
   always_comb begin
      hex_next  = '1;
      lead_zero = 1'b1;
      digit     = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         digit     = scratch[4*(DIGITS-1-i) +: 4];
         lead_zero = lead_zero & (digit == 4'd0);
         if (ovf_flag)
            hex_next[7*(DIGITS-1-i) +: 7] = SEG_DASH;
         else if ((BLANK_LZ != 0) && lead_zero && (i != DIGITS-1))
            hex_next[7*(DIGITS-1-i) +: 7] = SEG_BLANK;
         else
            hex_next[7*(DIGITS-1-i) +: 7] = seg7(digit);
      end
   end

   // Conversion datapath and registered results
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         shreg    <= '0;
         scratch  <= '0;
         ovf_flag <= 1'b0;
         cnt      <= '0;
         bcd_q    <= '0;
         hex_q    <= '1;
         ovf_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (accept) begin
            shreg    <= bus.binary;
            scratch  <= '0;
            ovf_flag <= 1'b0;
            cnt      <= CW'(WIDTH - 1);
         end else if (state == S_SHIFT) begin
            scratch <= {scratch_adj[4*DIGITS-2:0], shreg[WIDTH-1]};
            shreg   <= shreg << 1;
            cnt     <= cnt - CW'(1);
            if (scratch_adj[4*DIGITS-1]) ovf_flag <= 1'b1;
         end
         // Results sample scratch before a back-to-back accept clears it
         if (state == S_DONE) begin
            bcd_q  <= scratch;
            ovf_q  <= ovf_flag;
            hex_q  <= hex_next;
            done_q <= 1'b1;
         end
      end
   end

   assign bus.busy     = (state == S_SHIFT);
   assign bus.done     = done_q;
   assign bus.bcd      = bcd_q;
   assign bus.hex      = hex_q;
   assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_bcd_sevenseg_seq.sv
// Self-checking bench for bcd_sevenseg_seq: three instances (8b/3 digits,
// 8b/2 digits, 32b/10 digits) compared against a decimal arithmetic model.
module tb_bcd_sevenseg_seq;

   logic clock;
   logic resetn;
   int   n_assert;
   int   n_fail;

   localparam logic [6:0] SEG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                       7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                       7'b0000000, 7'b0010000};

   bcd_sevenseg_seq_if #(.WIDTH(8),  .DIGITS(3))  a_if ();
   bcd_sevenseg_seq_if #(.WIDTH(8),  .DIGITS(2))  b_if ();
   bcd_sevenseg_seq_if #(.WIDTH(32), .DIGITS(10)) c_if ();

   bcd_sevenseg_seq #(.WIDTH(8),  .DIGITS(3),  .BLANK_LZ(1)) u_a (.clock(clock), .resetn(resetn), .bus(a_if));
   bcd_sevenseg_seq #(.WIDTH(8),  .DIGITS(2),  .BLANK_LZ(1)) u_b (.clock(clock), .resetn(resetn), .bus(b_if));
   bcd_sevenseg_seq #(.WIDTH(32), .DIGITS(10), .BLANK_LZ(1)) u_c (.clock(clock), .resetn(resetn), .bus(c_if));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Decimal model: digits by repeated division, blanking above the most significant non-zero digit
   task automatic model(input longint unsigned v, input int digits,
                        output logic [39:0] eb, output logic [69:0] eh, output logic eo);
      longint unsigned rem, lim;
      int d [10];
      int msd;
      lim = 1;
      for (int k = 0; k < digits; k++) lim = lim * 10;
      eo  = (v >= lim);
      rem = v;
      eb  = '0;
      eh  = '0;
      msd = 0;
      for (int k = 0; k < digits; k++) begin
         d[k] = int'(rem % 10);
         rem  = rem / 10;
         eb[4*k +: 4] = 4'(d[k]);
         if (d[k] != 0) msd = k;
      end
      for (int k = 0; k < digits; k++) begin
         if (eo)           eh[7*k +: 7] = 7'b0111111;
         else if (k > msd) eh[7*k +: 7] = 7'b1111111;
         else              eh[7*k +: 7] = SEG[d[k]];
      end
   endtask

   task automatic drive(input int sel, input logic s, input logic [31:0] v);
      case (sel)
         0: begin a_if.start = s; a_if.binary = v[7:0]; end
         1: begin b_if.start = s; b_if.binary = v[7:0]; end
         default: begin c_if.start = s; c_if.binary = v; end
      endcase
   endtask

   function automatic logic o_done(input int sel);
      case (sel)
         0: return a_if.done;
         1: return b_if.done;
         default: return c_if.done;
      endcase
   endfunction

   function automatic logic o_busy(input int sel);
      case (sel)
         0: return a_if.busy;
         1: return b_if.busy;
         default: return c_if.busy;
      endcase
   endfunction

   function automatic logic o_ovf(input int sel);
      case (sel)
         0: return a_if.overflow;
         1: return b_if.overflow;
         default: return c_if.overflow;
      endcase
   endfunction

   function automatic logic [39:0] o_bcd(input int sel);
      case (sel)
         0: return 40'(a_if.bcd);
         1: return 40'(b_if.bcd);
         default: return c_if.bcd;
      endcase
   endfunction

   function automatic logic [69:0] o_hex(input int sel);
      case (sel)
         0: return 70'(a_if.hex);
         1: return 70'(b_if.hex);
         default: return c_if.hex;
      endcase
   endfunction

   function automatic int digits_of(input int sel);
      return (sel == 0) ? 3 : (sel == 1) ? 2 : 10;
   endfunction

   function automatic int width_of(input int sel);
      return (sel == 2) ? 32 : 8;
   endfunction

   task automatic check_result(input int sel, input logic [31:0] v, input string tag);
      logic [39:0] eb;
      logic [69:0] eh;
      logic        eo;
      model(longint'(v), digits_of(sel), eb, eh, eo);
      chk({tag, ".bcd"}, 70'(o_bcd(sel)), 70'(eb));
      chk({tag, ".hex"}, o_hex(sel), eh);
      chk({tag, ".ovf"}, 70'(o_ovf(sel)), 70'(eo));
   endtask

   // Single conversion: pulse start, wait (bounded) for done, check latency, results and pulse width
   task automatic run_conv(input int sel, input logic [31:0] v, input string tag);
      int lat;
      drive(sel, 1'b1, v);
      @(posedge clock); #1;
      drive(sel, 1'b0, 32'h0);
      lat = 0;
      for (int c = 1; c <= 64; c++) begin
         @(posedge clock); #1;
         if (c == 1) chk({tag, ".busy"}, 70'(o_busy(sel)), 70'(1));
         if (o_done(sel)) begin
            lat = c;
            break;
         end
      end
      chk({tag, ".latency"}, 70'(lat), 70'(width_of(sel) + 1));
      chk({tag, ".busy_at_done"}, 70'(o_busy(sel)), 70'(0));
      check_result(sel, v, tag);
      @(posedge clock); #1;
      chk({tag, ".done_pulse"}, 70'(o_done(sel)), 70'(0));
   endtask

   initial begin
      logic [31:0] vals [8];
      int          ndone;
      int          gap;
      logic [39:0] cap_bcd;
      n_assert = 0;
      n_fail   = 0;
      resetn   = 1'b0;
      drive(0, 1'b0, 32'h0);
      drive(1, 1'b0, 32'h0);
      drive(2, 1'b0, 32'h0);
      repeat (3) @(posedge clock);
      #1;
      chk("reset.busy", 70'(a_if.busy), 70'(0));
      chk("reset.done", 70'(a_if.done), 70'(0));
      chk("reset.ovf",  70'(a_if.overflow), 70'(0));
      chk("reset.bcd",  70'(c_if.bcd), 70'(0));
      chk("reset.hex",  c_if.hex, {70{1'b1}});
      resetn = 1'b1;
      @(posedge clock); #1;

      // Directed values, including the hand-written display images
      run_conv(0, 32'd202, "dir202");
      chk("dir202.const_bcd", 70'(a_if.bcd), 70'(12'h202));
      chk("dir202.const_hex", 70'(a_if.hex), 70'({7'b0100100, 7'b1000000, 7'b0100100}));
      run_conv(0, 32'd7, "dir7");
      chk("dir7.const_hex", 70'(a_if.hex), 70'({7'b1111111, 7'b1111111, 7'b1111000}));
      run_conv(0, 32'd0, "dir0");
      chk("dir0.const_hex", 70'(a_if.hex), 70'({7'b1111111, 7'b1111111, 7'b1000000}));
      run_conv(1, 32'd255, "ovf255");
      chk("ovf255.const_bcd", 70'(b_if.bcd), 70'(8'h55));
      chk("ovf255.const_ovf", 70'(b_if.overflow), 70'(1));
      chk("ovf255.const_hex", 70'(b_if.hex), 70'({7'b0111111, 7'b0111111}));
      run_conv(1, 32'd99, "fit99");
      run_conv(1, 32'd100, "ovf100");
      run_conv(2, 32'hFFFF_FFFF, "max32");
      chk("max32.const_bcd", 70'(c_if.bcd), 70'(40'h42_9496_7295));

      // Random values on every instance
      for (int i = 0; i < 6; i++) begin
         run_conv(0, 32'($urandom_range(0, 255)), "rndA");
         run_conv(1, 32'($urandom_range(0, 255)), "rndB");
         run_conv(2, $urandom(), "rndC");
      end

      // Start while busy is ignored
      drive(0, 1'b1, 32'd99);
      @(posedge clock); #1;
      drive(0, 1'b0, 32'd0);
      ndone   = 0;
      cap_bcd = '0;
      for (int c = 1; c <= 20; c++) begin
         if (c == 3) drive(0, 1'b1, 32'd42);
         else        drive(0, 1'b0, 32'd42);
         @(posedge clock); #1;
         if (a_if.done) begin
            ndone++;
            cap_bcd = 40'(a_if.bcd);
         end
      end
      drive(0, 1'b0, 32'd0);
      chk("ignore.ndone", 70'(ndone), 70'(1));
      chk("ignore.bcd", 70'(cap_bcd), 70'(12'h099));

      // Start held high: back-to-back conversions, each from its own accept edge
      for (int i = 0; i < 8; i++) vals[i] = 32'($urandom_range(0, 255));
      drive(0, 1'b1, vals[0]);
      @(posedge clock); #1;
      drive(0, 1'b1, vals[1]);
      for (int j = 0; j < 6; j++) begin
         gap = 0;
         for (int c = 1; c <= 40; c++) begin
            @(posedge clock); #1;
            if (a_if.done) begin
               gap = c;
               break;
            end
         end
         chk("stream.gap", 70'(gap), 70'(9));
         check_result(0, vals[j], "stream");
         if (j == 4) drive(0, 1'b0, 32'd0);
         else if (j < 4) drive(0, 1'b1, vals[j+2]);
      end

      // Asynchronous reset in the middle of a conversion
      drive(0, 1'b1, 32'd123);
      @(posedge clock); #1;
      drive(0, 1'b0, 32'd0);
      repeat (3) @(posedge clock);
      #1;
      resetn = 1'b0;
      #1;
      chk("midrst.busy", 70'(a_if.busy), 70'(0));
      chk("midrst.done", 70'(a_if.done), 70'(0));
      chk("midrst.ovf",  70'(a_if.overflow), 70'(0));
      chk("midrst.bcd",  70'(a_if.bcd), 70'(0));
      chk("midrst.hex",  70'(a_if.hex), 70'({21{1'b1}}));
      @(posedge clock); #1;
      resetn = 1'b1;
      ndone = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clock); #1;
         if (a_if.done) ndone++;
      end
      chk("midrst.no_done", 70'(ndone), 70'(0));
      run_conv(0, 32'($urandom_range(0, 255)), "postrst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
